// File: rtl/run_pattern_tx_pkg.sv
// Shared types for the run-length pattern transmitter and the benches that
// model its expected output.
package run_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } statetype;

endpackage

// File: rtl/run_pattern_tx_req_fifo2.sv
// Two-entry request FIFO. Pushes while full and pops while empty are ignored,
// so a simultaneous push and pop on a non-full queue is always safe.
module req_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/run_pattern_tx.sv
// Serial run-length pattern transmitter: each queued request of length N
// produces N ones on `a` followed by GAP zeros, with a `done` pulse per request.
module run_pattern_tx #(
  parameter int CW  = 4,
  parameter int GAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [CW-1:0]        req_len,
  output logic                 req_ready,
  output logic                 a,
  output logic                 busy,
  output logic                 done,
  output run_tx_pkg::statetype state_dbg
);
  import run_tx_pkg::*;

  // Handshake: a request is taken on every rising edge where req_valid and
  // req_ready are both high; req_len must be stable while req_valid is high.

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP);

  statetype      state;
  statetype      state_nxt;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          head_zero;
  logic          gap_last;
  logic          zero_pend;

  assign push      = req_valid && req_ready;
  assign head_zero = (head == '0);
  assign gap_last  = (state == run_tx_pkg::GAP) && (gap_cnt == ONE);
  assign state_dbg = state;

  req_fifo2 #(.W(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req_len),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero-length head found in IDLE is held back while the previous
  // zero-length done is still pending, so the two pulses never merge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !(zero_pend && head_zero)) begin
          pop = 1'b1;
          if (!head_zero) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (run_cnt == ONE) begin
          state_nxt = run_tx_pkg::GAP;
        end
      end
      run_tx_pkg::GAP: begin
        if (gap_cnt == ONE) begin
          state_nxt = IDLE;
          if (!empty) begin
            pop = 1'b1;
            if (!head_zero) begin
              state_nxt = RUN;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters stop at 1 and are reloaded with nonzero values only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt   <= '0;
      gap_cnt   <= '0;
      zero_pend <= 1'b0;
    end else begin
      zero_pend <= gap_last && pop && head_zero;
      if (pop && !head_zero) begin
        run_cnt <= head;
      end else if (state == RUN && run_cnt != ONE) begin
        run_cnt <= run_cnt - ONE;
      end
      if (state == RUN && run_cnt == ONE) begin
        gap_cnt <= GAP_LD;
      end else if (state == run_tx_pkg::GAP && gap_cnt != ONE) begin
        gap_cnt <= gap_cnt - ONE;
      end
    end
  end

  always_comb begin
    a         = (state == RUN);
    done      = gap_last || zero_pend || ((state == IDLE) && pop && head_zero);
    busy      = (state != IDLE) || !empty;
    req_ready = !full && !reset;
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Bench for run_pattern_tx: literal vector tables, held-valid and zero-length
// sequences, randomized traffic against a timeline model, reset abort, GAP=3.
module tb_run_pattern_tx;
  import run_tx_pkg::*;

  localparam int CW   = 4;
  localparam int GAP1 = 1;
  localparam int MAXC = 4096;

  // ---------------- clock / reset / DUTs ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid;
  logic [CW-1:0] req_len;
  logic          req_ready, a, busy, done;
  statetype      state_dbg;
  logic          v3;
  logic [CW-1:0] l3;
  logic          r3, a3, b3, d3;
  statetype      s3;

  always #5 clk = ~clk;

  run_pattern_tx #(.CW(CW), .GAP(GAP1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .a(a), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  run_pattern_tx #(.CW(CW), .GAP(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_len(l3),
    .req_ready(r3), .a(a3), .busy(b3), .done(d3), .state_dbg(s3)
  );

  // ---------------- result counters ----------------
  int n_vec;
  int n_bad;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // Each accepted request is placed on a cycle timeline: when it is popped,
  // which cycles carry ones, when its done pulse falls, and when the queue
  // slot frees up.
  bit            exp_a   [MAXC];
  bit            exp_d   [MAXC];
  bit            act_m   [MAXC];
  int            pop_cnt [MAXC];
  int            cyc, next_pop, last_done, occ, ones_cnt;
  bit            prev_nz;
  logic [CW-1:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      exp_a[i] = 1'b0; exp_d[i] = 1'b0; act_m[i] = 1'b0; pop_cnt[i] = 0;
    end
    cyc = 0; next_pop = 0; last_done = -10; occ = 0; ones_cnt = 0; prev_nz = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int t, input logic [CW-1:0] n);
    int p;
    int d;
    int nn;
    nn = int'(n);
    p  = (t + 1 > next_pop) ? t + 1 : next_pop;
    if (nn > 0) begin
      for (int c = p + 1; c <= p + nn; c++) begin
        exp_a[c] = 1'b1; act_m[c] = 1'b1;
      end
      for (int c = p + nn + 1; c <= p + nn + GAP1; c++) act_m[c] = 1'b1;
      d = p + nn + GAP1;
      exp_d[d] = 1'b1;
      pop_cnt[p]++;
      next_pop = d; last_done = d; prev_nz = 1'b1;
    end else if (prev_nz && p == next_pop) begin
      // popped at the end of a gap: done shows in the following idle cycle
      pop_cnt[p]++;
      exp_d[p + 1] = 1'b1;
      next_pop = p + 1; last_done = p + 1; prev_nz = 1'b0;
    end else begin
      d = (p > last_done + 1) ? p : last_done + 1;
      pop_cnt[d]++;
      exp_d[d] = 1'b1;
      next_pop = d + 1; last_done = d; prev_nz = 1'b0;
    end
    exp_q.push_back(n);
  endtask

  // One cycle: check outputs against the model, then drive this cycle's input.
  task automatic step(input bit v, input logic [CW-1:0] l, output bit acc);
    @(negedge clk);
    check_bit($sformatf("a c%0d", cyc), a, exp_a[cyc]);
    check_bit($sformatf("done c%0d", cyc), done, exp_d[cyc]);
    check_bit($sformatf("busy c%0d", cyc), busy, act_m[cyc] || (occ > 0));
    check_bit($sformatf("req_ready c%0d", cyc), req_ready, occ < 2);
    if (a === 1'b1) ones_cnt++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done c%0d: got done=1, expected no pending request", cyc);
      end else begin
        check_int($sformatf("run_len c%0d", cyc), ones_cnt, int'(exp_q.pop_front()));
      end
      ones_cnt = 0;
    end
    req_valid = v;
    req_len   = l;
    acc = v && (occ < 2);
    if (acc) model_accept(cyc, l);
    occ = occ + int'(acc) - pop_cnt[cyc];
    cyc++;
  endtask

  task automatic run_held(input logic [CW-1:0] lens[$], input string tag);
    bit acc;
    int guard;
    guard = 0;
    while (lens.size() > 0 && guard < 200) begin
      step(1'b1, lens[0], acc);
      if (acc) void'(lens.pop_front());
      guard++;
    end
    if (lens.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s_accept_timeout: got %0d requests left, expected 0", tag, lens.size());
    end
    repeat (40) step(1'b0, '0, acc);
    check_int({tag, "_pending_after_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- literal vector tables ----------------
  typedef struct {
    logic          v;
    logic [CW-1:0] len;
    logic          ea, ed, eb, er;
  } vec_t;

  vec_t tbl[15];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit            acc;
    bit            v;
    logic [CW-1:0] l;
    int            r;
    logic [CW-1:0] lens[$];

    n_vec = 0; n_bad = 0;
    req_valid = 1'b0; req_len = '0; v3 = 1'b0; l3 = '0;

    // single len=3 request, GAP=1
    tbl[0]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    // len=1 then len=2 on consecutive cycles
    tbl[7]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_a", a, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_req_ready", req_ready, 1'b0);
    check_bit("rst_state_idle", state_dbg == IDLE, 1'b1);
    check_bit("rst_gap3_req_ready", r3, 1'b0);
    reset = 1'b0;
    #1;
    check_bit("rel_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_bit($sformatf("tbl%0d_a", i), a, tbl[i].ea);
      check_bit($sformatf("tbl%0d_done", i), done, tbl[i].ed);
      check_bit($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      check_bit($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].er);
      req_valid = tbl[i].v;
      req_len   = tbl[i].len;
    end

    // three requests behind a long run while valid is held
    model_clear();
    lens = '{4'd5, 4'd2, 4'd3, 4'd4};
    run_held(lens, "held");

    // zero-length request between two runs, plus consecutive zero lengths
    model_clear();
    lens = '{4'd2, 4'd0, 4'd2, 4'd0, 4'd0, 4'd1};
    run_held(lens, "zero");

    // randomized traffic
    model_clear();
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 2)      l = '0;
      else if (r < 7) l = CW'($urandom_range(1, 3));
      else            l = CW'($urandom_range(4, 15));
      step(v, l, acc);
    end
    repeat (60) step(1'b0, '0, acc);
    check_int("rand_pending_after_drain", exp_q.size(), 0);

    // reset during the 4th cycle of a 10-cycle run, with a second request queued
    @(negedge clk); req_valid = 1'b1; req_len = 4'd10;
    @(negedge clk); req_len = 4'd4;
    @(negedge clk); req_valid = 1'b0; req_len = '0;
    check_bit("abort_run_c2_a", a, 1'b1);
    repeat (3) @(negedge clk);
    check_bit("abort_run_c5_a", a, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_bit("abort_a_drops", a, 1'b0);
    check_bit("abort_req_ready", req_ready, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("abort_rel_req_ready", req_ready, 1'b1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check_bit($sformatf("abort_after%0d_a", c), a, 1'b0);
      check_bit($sformatf("abort_after%0d_done", c), done, 1'b0);
      check_bit($sformatf("abort_after%0d_busy", c), busy, 1'b0);
    end

    // GAP=3 instance, maximum run length
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      check_bit($sformatf("gap3 c%0d a", c), a3, (c >= 2) && (c <= 16));
      check_bit($sformatf("gap3 c%0d done", c), d3, c == 19);
      check_bit($sformatf("gap3 c%0d busy", c), b3, (c >= 1) && (c <= 19));
      check_bit($sformatf("gap3 c%0d req_ready", c), r3, 1'b1);
      v3 = (c == 0);
      l3 = 4'd15;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
